if_fetch: RTL and testbench

Instruction-fetch stage between the PC register and the IF/ID pipeline register. Takes the current `pc`/`ce` and issues a read on the instruction bus with a req/ack handshake. Returns the fetched word, its PC and fetch exceptions to IF/ID. It requests a pipeline stall while the bus is slow, and holds a completed fetch when IF/ID is stalled, so no word is lost or fetched twice.

---
 rtl/if_fetch_pkg.sv | 28 ++
 rtl/if_fetch_if.sv | 27 ++
 rtl/if_fetch.sv | 152 +++++++++++++++
 tb/tb_if_fetch.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: pipeline control
// encodings, FSM states and the record passed to IF/ID.
package if_fetch_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam int IF_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

  // One completed fetch as seen by IF/ID; also the layout of the hold buffer.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
    logic        ibe;
  } fetch_word_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction bus between the fetch stage (master) and memory (slave):
// single read request with a req/ack handshake.
interface if_fetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    output mem_err
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues bus reads for the current PC, stalls the
// pipeline while the bus is slow and holds a finished word while IF/ID stalls.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int TIMEOUT = IF_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc,
  input  logic         ce,
  input  logic [5:0]   stall,
  if_fetch_if.master   bus,
  output logic         stallreq_o,
  output logic [31:0]  inst_o,
  output logic [31:0]  inst_pc_o,
  output logic         inst_valid_o,
  output logic         excp_adel_o,
  output logic         excp_ibe_o
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  if_state_e   state, state_next;
  logic [7:0]  wait_cnt, wait_next;
  fetch_word_t hold, word;
  logic        done;
  logic        capture;
  logic        req;
  logic        stallreq;
  logic        valid;
  logic        unused_stall;

  // Only the IF/ID hold bit matters to this stage.
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign bus.mem_addr = pc;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IF_IDLE;
      wait_cnt <= '0;
      hold     <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (capture) hold <= word;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    wait_next  = '0;
    capture    = 1'b0;
    case (state)
      IF_IDLE: begin
        if (ce == CHIP_ENABLE) state_next = IF_FETCH;
      end
      IF_FETCH: begin
        // A flush wins over everything: the word (if any) is shown once.
        if (ce == CHIP_DISABLE) begin
          state_next = IF_IDLE;
        end else if (done) begin
          if (stall[1] == STOP) begin
            capture    = 1'b1;
            state_next = IF_HOLD;
          end
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      IF_HOLD: begin
        if (ce == CHIP_DISABLE)    state_next = IF_IDLE;
        else if (stall[1] == NO_STOP) state_next = IF_FETCH;
      end
      default: state_next = IF_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    req      = 1'b0;
    stallreq = 1'b0;
    valid    = 1'b0;
    done     = 1'b0;
    word     = '0;
    case (state)
      IF_FETCH: begin
        if (pc[1:0] != 2'b00) begin
          // Misaligned: raise AdEL without touching the bus.
          done      = 1'b1;
          word.pc   = pc;
          word.adel = 1'b1;
        end else begin
          req = 1'b1;
          if (bus.mem_ack) begin
            done      = 1'b1;
            word.pc   = pc;
            word.inst = bus.mem_err ? ZERO_WORD : bus.mem_rdata;
            word.ibe  = bus.mem_err;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            done     = 1'b1;
            word.pc  = pc;
            word.ibe = 1'b1;
          end else begin
            stallreq = 1'b1;
          end
        end
        valid = done;
      end
      IF_HOLD: begin
        word  = hold;
        valid = 1'b1;
      end
      default: ;
    endcase

    // Reset and chip-disable abandon the request in the same cycle.
    if (ce == CHIP_DISABLE) begin
      req      = 1'b0;
      stallreq = 1'b0;
    end
    if (!rst) begin
      req      = 1'b0;
      stallreq = 1'b0;
      valid    = 1'b0;
      done     = 1'b0;
      word     = '0;
    end
  end

  assign bus.mem_req  = req;
  assign stallreq_o   = stallreq;
  assign inst_valid_o = valid;
  assign inst_o       = word.inst;
  assign inst_pc_o    = word.pc;
  assign excp_adel_o  = word.adel;
  assign excp_ibe_o   = word.ibe;

endmodule

// File: tb/tb_if_fetch.sv
// Directed, table-driven bench for if_fetch: one vector per clock cycle with
// hand-computed outputs, plus a hand-written bus-timeout sequence.
module tb_if_fetch;

  typedef struct {
    string       name;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        stop;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        e_req;
    logic        e_stallreq;
    logic        e_valid;
    logic        e_adel;
    logic        e_ibe;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        stallreq_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        excp_adel_o;
  logic        excp_ibe_o;

  int n_vec  = 0;
  int n_fail = 0;

  vec_t vecs[$];

  if_fetch_if bus ();

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ce           (ce),
    .stall        (stall),
    .bus          (bus),
    .stallreq_o   (stallreq_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o),
    .excp_adel_o  (excp_adel_o),
    .excp_ibe_o   (excp_ibe_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic r, logic c, logic [31:0] p,
                              logic stp, logic a, logic [31:0] rd, logic e,
                              logic x_req, logic x_stl, logic x_val,
                              logic x_adel, logic x_ibe,
                              logic [31:0] x_inst, logic [31:0] x_pc);
    vec_t v;
    v.name = name; v.rst = r; v.ce = c; v.pc = p; v.stop = stp;
    v.ack = a; v.rdata = rd; v.err = e;
    v.e_req = x_req; v.e_stallreq = x_stl; v.e_valid = x_val;
    v.e_adel = x_adel; v.e_ibe = x_ibe; v.e_inst = x_inst; v.e_pc = x_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [100:0] act,
                       input logic [100:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got req/stl/val/adel/ibe=%b inst=%h pc=%h addr=%h, want %b inst=%h pc=%h addr=%h",
               name, act[100:96], act[95:64], act[63:32], act[31:0],
               exp[100:96], exp[95:64], exp[63:32], exp[31:0]);
    end
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then advance past the edge.
  task automatic apply(input vec_t v);
    rst           = v.rst;
    ce            = v.ce;
    pc            = v.pc;
    stall         = {4'b0000, v.stop, 1'b0};
    bus.mem_ack   = v.ack;
    bus.mem_rdata = v.rdata;
    bus.mem_err   = v.err;
    @(negedge clk);
    check(v.name,
          {bus.mem_req, stallreq_o, inst_valid_o, excp_adel_o, excp_ibe_o,
           inst_o, inst_pc_o, bus.mem_addr},
          {v.e_req, v.e_stallreq, v.e_valid, v.e_adel, v.e_ibe,
           v.e_inst, v.e_pc, v.pc});
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               name          rst ce pc        stp ack rdata          err  req stl val adel ibe inst           pc
    vecs.push_back(mk("rst0",      0, 0, 32'h00,  0, 0, 32'h0,          0,   0, 0, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("rst1",      0, 1, 32'h00,  0, 1, 32'h12345678,   0,   0, 0, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("idle_ce",   1, 1, 32'h00,  0, 0, 32'h0,          0,   0, 0, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("zw_pc0",    1, 1, 32'h00,  0, 1, 32'h24010001,   0,   1, 0, 1, 0, 0, 32'h24010001,   32'h00));
    vecs.push_back(mk("zw_pc4",    1, 1, 32'h04,  0, 1, 32'h24020002,   0,   1, 0, 1, 0, 0, 32'h24020002,   32'h04));
    vecs.push_back(mk("zw_pc8",    1, 1, 32'h08,  0, 1, 32'h24030003,   0,   1, 0, 1, 0, 0, 32'h24030003,   32'h08));
    vecs.push_back(mk("wait1",     1, 1, 32'h10,  0, 0, 32'h0,          0,   1, 1, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("wait2",     1, 1, 32'h10,  0, 0, 32'h0,          0,   1, 1, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("wait3",     1, 1, 32'h10,  0, 0, 32'h0,          0,   1, 1, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("wait_ack",  1, 1, 32'h10,  0, 1, 32'hAABBCCDD,   0,   1, 0, 1, 0, 0, 32'hAABBCCDD,   32'h10));
    vecs.push_back(mk("ack_stop",  1, 1, 32'h14,  1, 1, 32'h11112222,   0,   1, 0, 1, 0, 0, 32'h11112222,   32'h14));
    vecs.push_back(mk("hold1",     1, 1, 32'h18,  1, 0, 32'h0,          0,   0, 0, 1, 0, 0, 32'h11112222,   32'h14));
    vecs.push_back(mk("hold2",     1, 1, 32'h18,  0, 1, 32'hFFFFFFFF,   0,   0, 0, 1, 0, 0, 32'h11112222,   32'h14));
    vecs.push_back(mk("after_hold",1, 1, 32'h18,  0, 1, 32'h33334444,   0,   1, 0, 1, 0, 0, 32'h33334444,   32'h18));
    vecs.push_back(mk("adel",      1, 1, 32'h06,  0, 1, 32'h55555555,   0,   0, 0, 1, 1, 0, 32'h0,          32'h06));
    vecs.push_back(mk("bus_err",   1, 1, 32'h20,  0, 1, 32'hDEADBEEF,   1,   1, 0, 1, 0, 1, 32'h0,          32'h20));
    vecs.push_back(mk("ack_ce_dn", 1, 0, 32'h24,  0, 1, 32'h55556666,   0,   0, 0, 1, 0, 0, 32'h55556666,   32'h24));
    vecs.push_back(mk("idle_ack",  1, 0, 32'h24,  0, 1, 32'h77777777,   0,   0, 0, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("idle_ce2",  1, 1, 32'h28,  0, 0, 32'h0,          0,   0, 0, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("pend",      1, 1, 32'h28,  0, 0, 32'h0,          0,   1, 1, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("rst_pend",  0, 1, 32'h28,  0, 0, 32'h0,          0,   0, 0, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("stale_ack", 1, 1, 32'h28,  0, 1, 32'h77777777,   0,   0, 0, 0, 0, 0, 32'h0,          32'h00));
    vecs.push_back(mk("refetch",   1, 1, 32'h28,  0, 0, 32'h0,          0,   1, 1, 0, 0, 0, 32'h0,          32'h00));

    #1;
    foreach (vecs[i]) apply(vecs[i]);

    // Timeout: 255 stall cycles, then a bus-error completion at wait 255.
    apply(mk("to_rst",  0, 1, 32'h40, 0, 0, 32'h0, 0,  0, 0, 0, 0, 0, 32'h0, 32'h00));
    apply(mk("to_idle", 1, 1, 32'h40, 0, 0, 32'h0, 0,  0, 0, 0, 0, 0, 32'h0, 32'h00));
    for (int i = 0; i < 255; i++)
      apply(mk("to_wait", 1, 1, 32'h40, 0, 0, 32'h0, 0,  1, 1, 0, 0, 0, 32'h0, 32'h00));
    apply(mk("to_done", 1, 1, 32'h40, 0, 0, 32'h0, 0,  1, 0, 1, 0, 1, 32'h0, 32'h40));
    // The counter restarts for the next request.
    apply(mk("to_next", 1, 1, 32'h40, 0, 0, 32'h0, 0,  1, 1, 0, 0, 0, 32'h0, 32'h00));
    apply(mk("to_ack",  1, 1, 32'h40, 0, 1, 32'hCAFEF00D, 0,  1, 0, 1, 0, 0, 32'hCAFEF00D, 32'h40));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
